// File: rtl/mdio_slave_22_45_backend.sv
// MDIO slave backend: decodes Clause 22/45 frames from frontend strobes into register-bus
// transactions, returns read data to the frontend and owns the Clause 45 MMD address.
module mdio_slave_22_45_backend #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter logic [15:0] RD_ERR_DATA = 16'hFFFF
) (
    input  logic        clk_25m,
    input  logic        rst,
    input  logic        c45_enable,
    input  logic        legal,
    input  logic [31:0] req_data,
    input  logic        req_regaddr_done,
    input  logic        req_frame_done,
    output logic [15:0] resp_rdata,
    output logic        resp_ready,
    output logic        bus_req,
    output logic        bus_wr,
    output logic        bus_c45,
    output logic [4:0]  bus_devad,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [15:0] bus_rdata,
    output logic        err_timeout
);

    localparam int unsigned DW    = 16;
    localparam int unsigned RW    = 5;
    localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD      = 2'd1;
    localparam logic [1:0] S_WR      = 2'd2;
    localparam logic [1:0] S_RESTART = 2'd3;

    logic [1:0]       state, state_nxt;
    logic [TMO_W-1:0] tmo, tmo_nxt;
    logic             op_inc, op_inc_nxt;
    logic [DW-1:0]    mmd_addr, mmd_addr_nxt;
    logic [RW-1:0]    mmd_devad, mmd_devad_nxt;
    logic             pend_valid, pend_valid_nxt;
    logic             pend_c45, pend_c45_nxt;
    logic             pend_adr, pend_adr_nxt;
    logic [RW-1:0]    pend_reg, pend_reg_nxt;
    logic [DW-1:0]    pend_data, pend_data_nxt;
    logic [DW-1:0]    resp_rdata_nxt;
    logic             resp_ready_nxt;
    logic             bus_req_nxt, bus_wr_nxt, bus_c45_nxt, err_timeout_nxt;
    logic [RW-1:0]    bus_devad_nxt;
    logic [DW-1:0]    bus_addr_nxt, bus_wdata_nxt;

    // Frame field decode
    logic [1:0]    f_st, f_op;
    logic [RW-1:0] f_reg;
    logic [DW-1:0] f_data;
    logic          is_c22, is_c45, hdr_ok, rd_start, rd_inc, frm_ok, frm_adr, frm_direct;
    logic          unused_bits;

    assign f_st   = req_data[31:30];
    assign f_op   = req_data[29:28];
    assign f_reg  = req_data[22:18];
    assign f_data = req_data[15:0];
    assign unused_bits = ^{req_data[27:23], req_data[17:16]};

    assign is_c22   = (f_st == 2'b01);
    assign is_c45   = (f_st == 2'b00) && c45_enable;
    assign hdr_ok   = req_regaddr_done && legal
                      && ((is_c22 && (f_op == 2'b10 || f_op == 2'b01)) || is_c45);
    assign rd_inc   = is_c45 && (f_op == 2'b10);
    assign rd_start = req_regaddr_done && legal
                      && ((is_c22 && f_op == 2'b10) || (is_c45 && f_op[1]));
    assign frm_adr  = is_c45 && (f_op == 2'b00);
    assign frm_ok   = req_frame_done && legal && (((is_c22 || is_c45) && f_op == 2'b01) || frm_adr);
    assign frm_direct = frm_ok && (state == S_IDLE) && !rd_start && !pend_valid;

    // Action taken on a write/address frame, either fresh or from the pending slot
    logic          act_valid, act_c45, act_adr;
    logic [RW-1:0] act_reg;
    logic [DW-1:0] act_data;

    always_comb begin
        state_nxt       = state;
        tmo_nxt         = tmo;
        op_inc_nxt      = op_inc;
        mmd_addr_nxt    = mmd_addr;
        mmd_devad_nxt   = mmd_devad;
        pend_valid_nxt  = pend_valid;
        pend_c45_nxt    = pend_c45;
        pend_adr_nxt    = pend_adr;
        pend_reg_nxt    = pend_reg;
        pend_data_nxt   = pend_data;
        resp_rdata_nxt  = resp_rdata;
        resp_ready_nxt  = resp_ready;
        bus_req_nxt     = bus_req;
        bus_wr_nxt      = bus_wr;
        bus_c45_nxt     = bus_c45;
        bus_devad_nxt   = bus_devad;
        bus_addr_nxt    = bus_addr;
        bus_wdata_nxt   = bus_wdata;
        err_timeout_nxt = 1'b0;
        act_valid       = 1'b0;
        act_c45         = 1'b0;
        act_adr         = 1'b0;
        act_reg         = '0;
        act_data        = '0;

        case (state)
            S_IDLE: begin
                if (!rd_start && pend_valid) begin
                    act_valid      = 1'b1;
                    act_c45        = pend_c45;
                    act_adr        = pend_adr;
                    act_reg        = pend_reg;
                    act_data       = pend_data;
                    pend_valid_nxt = 1'b0;
                end else if (frm_direct) begin
                    act_valid = 1'b1;
                    act_c45   = is_c45;
                    act_adr   = frm_adr;
                    act_reg   = f_reg;
                    act_data  = f_data;
                end
            end
            S_RD, S_WR: begin
                // Ack has priority over a simultaneous timeout
                if (bus_ack || tmo == TMO_LAST) begin
                    bus_req_nxt     = 1'b0;
                    state_nxt       = S_IDLE;
                    err_timeout_nxt = !bus_ack;
                    if (state == S_RD) begin
                        resp_ready_nxt = 1'b1;
                        resp_rdata_nxt = bus_ack ? bus_rdata : RD_ERR_DATA;
                        if (op_inc) begin
                            mmd_addr_nxt = mmd_addr + 16'd1;
                        end
                    end
                end else begin
                    tmo_nxt = tmo + TMO_W'(1);
                end
            end
            default: begin
                if (!rd_start) begin
                    bus_req_nxt = 1'b1;
                    tmo_nxt     = '0;
                    state_nxt   = S_RD;
                end
            end
        endcase

        if (act_valid) begin
            if (act_adr) begin
                mmd_addr_nxt  = act_data;
                mmd_devad_nxt = act_reg;
            end else begin
                bus_req_nxt   = 1'b1;
                bus_wr_nxt    = 1'b1;
                bus_c45_nxt   = act_c45;
                bus_devad_nxt = act_c45 ? act_reg : '0;
                bus_addr_nxt  = act_c45 ? mmd_addr : {11'b0, act_reg};
                bus_wdata_nxt = act_data;
                op_inc_nxt    = 1'b0;
                tmo_nxt       = '0;
                state_nxt     = S_WR;
            end
        end

        // A new read header always starts a read; when busy, bus_req drops for one cycle first
        if (rd_start) begin
            bus_wr_nxt    = 1'b0;
            bus_c45_nxt   = is_c45;
            bus_devad_nxt = is_c45 ? f_reg : '0;
            bus_addr_nxt  = is_c45 ? mmd_addr_nxt : {11'b0, f_reg};
            op_inc_nxt    = rd_inc;
            if (state == S_IDLE) begin
                bus_req_nxt = 1'b1;
                tmo_nxt     = '0;
                state_nxt   = S_RD;
            end else begin
                bus_req_nxt     = 1'b0;
                err_timeout_nxt = 1'b0;
                state_nxt       = S_RESTART;
            end
        end

        if (frm_ok && !frm_direct) begin
            pend_valid_nxt = 1'b1;
            pend_c45_nxt   = is_c45;
            pend_adr_nxt   = frm_adr;
            pend_reg_nxt   = f_reg;
            pend_data_nxt  = f_data;
        end

        if (hdr_ok) begin
            resp_ready_nxt = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk_25m or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            tmo         <= '0;
            op_inc      <= 1'b0;
            mmd_addr    <= '0;
            mmd_devad   <= '0;
            pend_valid  <= 1'b0;
            pend_c45    <= 1'b0;
            pend_adr    <= 1'b0;
            pend_reg    <= '0;
            pend_data   <= '0;
            resp_rdata  <= RD_ERR_DATA;
            resp_ready  <= 1'b0;
            bus_req     <= 1'b0;
            bus_wr      <= 1'b0;
            bus_c45     <= 1'b0;
            bus_devad   <= '0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            tmo         <= tmo_nxt;
            op_inc      <= op_inc_nxt;
            mmd_addr    <= mmd_addr_nxt;
            mmd_devad   <= mmd_devad_nxt;
            pend_valid  <= pend_valid_nxt;
            pend_c45    <= pend_c45_nxt;
            pend_adr    <= pend_adr_nxt;
            pend_reg    <= pend_reg_nxt;
            pend_data   <= pend_data_nxt;
            resp_rdata  <= resp_rdata_nxt;
            resp_ready  <= resp_ready_nxt;
            bus_req     <= bus_req_nxt;
            bus_wr      <= bus_wr_nxt;
            bus_c45     <= bus_c45_nxt;
            bus_devad   <= bus_devad_nxt;
            bus_addr    <= bus_addr_nxt;
            bus_wdata   <= bus_wdata_nxt;
            err_timeout <= err_timeout_nxt;
        end
    end

endmodule
